// File: rtl/tetris_pkg.sv
// Shared Tetris definitions: score FSM states, line-clear point table and limits.
package tetris_pkg;

    localparam int SCORE_W         = 9;
    localparam int SCORE_MAX       = 511;
    localparam int LINES_PER_LEVEL = 10;
    localparam int LEVEL_MAX       = 15;
    localparam int LINES_MAX       = 1023;

    // Base points per event for 1..4 cleared lines, before the level multiplier
    localparam logic [3:0] PTS_1 = 4'd1;
    localparam logic [3:0] PTS_2 = 4'd3;
    localparam logic [3:0] PTS_3 = 4'd5;
    localparam logic [3:0] PTS_4 = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_COMMIT = 2'd2
    } score_state_t;

    // Base points for a line count; anything outside 1..4 is worth nothing
    function automatic logic [3:0] pts_base(input logic [2:0] n);
        case (n)
            3'd1:    return PTS_1;
            3'd2:    return PTS_2;
            3'd3:    return PTS_3;
            3'd4:    return PTS_4;
            default: return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/score_points_lut.sv
// Combinational points lookup: base points for the line count times (level + 1).
module score_points_lut
    import tetris_pkg::*;
(
    input  logic [2:0] clear_lines,
    input  logic [3:0] level,
    output logic [7:0] pts
);

    logic [4:0] multiplier;
    logic [8:0] product;

    // Scale the base points by the level multiplier; 8 * 16 = 128 is the largest result
    always_comb begin
        // NOTE: every output of a combinational block is assigned on every path, so no latch can be inferred.
        multiplier = {1'b0, level} + 5'd1;
        product    = {5'd0, pts_base(clear_lines)} * {4'd0, multiplier};
        pts        = product[7:0];
    end

endmodule

// File: rtl/score_keeper.sv
// Tetris score keeper: accepts line-clear events, accumulates a saturating score,
// tracks level and total lines, and exposes a frame-synchronised score for display.
module score_keeper
    import tetris_pkg::*;
#(
    parameter int SCORE_W         = tetris_pkg::SCORE_W,
    parameter int SCORE_MAX       = tetris_pkg::SCORE_MAX,
    parameter int LINES_PER_LEVEL = tetris_pkg::LINES_PER_LEVEL,
    parameter int LEVEL_MAX       = tetris_pkg::LEVEL_MAX,
    parameter int LINES_MAX       = tetris_pkg::LINES_MAX
) (
    input  logic               clk_25MHz,
    input  logic               rst_n,
    input  logic               game_restart,
    input  logic               frame_start,
    input  logic               clear_valid,
    input  logic [2:0]         clear_lines,
    output logic               clear_ready,
    output logic [SCORE_W-1:0] score_disp,
    output logic [3:0]         level,
    output logic [9:0]         lines_total,
    output logic               score_sat
);

    score_state_t       state;
    logic [2:0]         lines_q;        // line count captured at accept
    logic [7:0]         pts_q;          // points computed in CALC
    logic [2:0]         add_q;          // lines to credit (0 for an illegal count)
    logic [SCORE_W-1:0] score_acc;
    logic [3:0]         lines_in_level;

    logic [7:0]         lut_pts;
    logic               lines_legal;
    logic [SCORE_W:0]   score_sum;
    logic [4:0]         level_sum;
    logic [10:0]        lines_sum;

    score_points_lut u_lut (
        .clear_lines (lines_q),
        .level       (level),
        .pts         (lut_pts)
    );

    // Commit-stage arithmetic, one bit wider than each register so the clamp sees the overflow
    always_comb begin
        lines_legal = (lines_q >= 3'd1) && (lines_q <= 3'd4);
        score_sum   = {1'b0, score_acc} + (SCORE_W+1)'(pts_q);
        level_sum   = {1'b0, lines_in_level} + {2'b00, add_q};
        lines_sum   = {1'b0, lines_total} + {8'd0, add_q};
    end

    // Event FSM with all game state; restart wins over everything and aborts an in-flight event
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state          <= ST_IDLE;
            clear_ready    <= 1'b1;
            lines_q        <= '0;
            pts_q          <= '0;
            add_q          <= '0;
            score_acc      <= '0;
            lines_in_level <= '0;
            level          <= '0;
            lines_total    <= '0;
            score_sat      <= 1'b0;
        end else if (game_restart) begin
            state          <= ST_IDLE;
            clear_ready    <= 1'b1;
            lines_q        <= '0;
            pts_q          <= '0;
            add_q          <= '0;
            score_acc      <= '0;
            lines_in_level <= '0;
            level          <= '0;
            lines_total    <= '0;
            score_sat      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clear_valid && clear_ready) begin
                        lines_q     <= clear_lines;
                        clear_ready <= 1'b0;
                        state       <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    // Uses the level in force before this event commits
                    pts_q <= lut_pts;
                    add_q <= lines_legal ? lines_q : 3'd0;
                    state <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    if (score_sum >= (SCORE_W+1)'(SCORE_MAX)) begin
                        score_acc <= SCORE_W'(SCORE_MAX);
                        score_sat <= 1'b1;
                    end else begin
                        score_acc <= score_sum[SCORE_W-1:0];
                    end
                    if (lines_sum > 11'(LINES_MAX)) begin
                        lines_total <= 10'(LINES_MAX);
                    end else begin
                        lines_total <= lines_sum[9:0];
                    end
                    // At most one level step per event; the remainder carries into the next level
                    if (level_sum >= 5'(LINES_PER_LEVEL)) begin
                        lines_in_level <= 4'(level_sum - 5'(LINES_PER_LEVEL));
                        if (level < 4'(LEVEL_MAX)) begin
                            level <= level + 4'd1;
                        end
                    end else begin
                        lines_in_level <= level_sum[3:0];
                    end
                    clear_ready <= 1'b1;
                    state       <= ST_IDLE;
                end
                default: begin
                    clear_ready <= 1'b1;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

    // Display shadow: copies the score only at frame start, so a commit on the same edge shows next frame
    always_ff @(posedge clk_25MHz or negedge rst_n) begin
        if (!rst_n) begin
            score_disp <= '0;
        end else if (game_restart) begin
            score_disp <= '0;
        end else if (frame_start) begin
            score_disp <= score_acc;
        end
    end

endmodule

// File: tb/tb_score_keeper.sv
// Directed self-checking bench for score_keeper: inputs driven and outputs sampled on the falling edge.
module tb_score_keeper;

    logic       clk_25MHz;
    logic       rst_n;
    logic       game_restart;
    logic       frame_start;
    logic       clear_valid;
    logic [2:0] clear_lines;
    logic       clear_ready;
    logic [8:0] score_disp;
    logic [3:0] level;
    logic [9:0] lines_total;
    logic       score_sat;

    int checks = 0;
    int errors = 0;

    score_keeper dut (
        .clk_25MHz    (clk_25MHz),
        .rst_n        (rst_n),
        .game_restart (game_restart),
        .frame_start  (frame_start),
        .clear_valid  (clear_valid),
        .clear_lines  (clear_lines),
        .clear_ready  (clear_ready),
        .score_disp   (score_disp),
        .level        (level),
        .lines_total  (lines_total),
        .score_sat    (score_sat)
    );

    initial clk_25MHz = 1'b0;
    always #20 clk_25MHz = ~clk_25MHz;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Present one event, hold it until accepted, return after its commit edge
    task automatic do_event(input logic [2:0] n);
        int waited = 0;
        clear_valid = 1'b1;
        clear_lines = n;
        while (clear_ready !== 1'b1 && waited < 20) begin
            @(negedge clk_25MHz);
            waited++;
        end
        if (waited >= 20) check("accept_timeout", 32'(clear_ready), 32'd1);
        @(negedge clk_25MHz);
        clear_valid = 1'b0;
        @(negedge clk_25MHz);
        @(negedge clk_25MHz);
    endtask

    task automatic frame();
        frame_start = 1'b1;
        @(negedge clk_25MHz);
        frame_start = 1'b0;
    endtask

    task automatic restart();
        game_restart = 1'b1;
        @(negedge clk_25MHz);
        game_restart = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        game_restart = 1'b0;
        frame_start  = 1'b0;
        clear_valid  = 1'b0;
        clear_lines  = 3'd0;
        #50;
        check("rst_ready", 32'(clear_ready), 32'd1);
        check("rst_disp",  32'(score_disp),  32'd0);
        check("rst_level", 32'(level),       32'd0);
        check("rst_lines", 32'(lines_total), 32'd0);
        check("rst_sat",   32'(score_sat),   32'd0);
        @(negedge clk_25MHz);
        rst_n = 1'b1;
        @(negedge clk_25MHz);

        // 1: single n=4 at level 0, latency and shadow behaviour
        clear_valid = 1'b1;
        clear_lines = 3'd4;
        @(negedge clk_25MHz);
        clear_valid = 1'b0;
        check("t1_calc_ready", 32'(clear_ready), 32'd0);
        @(negedge clk_25MHz);
        check("t1_commit_ready", 32'(clear_ready), 32'd0);
        check("t1_lines_early",  32'(lines_total), 32'd0);
        @(negedge clk_25MHz);
        check("t1_lines",      32'(lines_total), 32'd4);
        check("t1_ready_back", 32'(clear_ready), 32'd1);
        check("t1_disp_stale", 32'(score_disp),  32'd0);
        frame();
        check("t1_disp", 32'(score_disp), 32'd8);

        // 2: ten single lines reach level 1; the next single scores double
        restart();
        for (int i = 0; i < 10; i++) do_event(3'd1);
        check("t2_lines10", 32'(lines_total), 32'd10);
        check("t2_level1",  32'(level),       32'd1);
        frame();
        check("t2_score10", 32'(score_disp), 32'd10);
        do_event(3'd1);
        frame();
        check("t2_score12", 32'(score_disp),  32'd12);
        check("t2_lines11", 32'(lines_total), 32'd11);

        // 3: sixteen tetrises give 464 at level 6; the seventeenth clamps at 511
        restart();
        for (int i = 0; i < 16; i++) do_event(3'd4);
        check("t3_level6",  32'(level),       32'd6);
        check("t3_lines64", 32'(lines_total), 32'd64);
        check("t3_sat0",    32'(score_sat),   32'd0);
        frame();
        check("t3_score464", 32'(score_disp), 32'd464);
        do_event(3'd4);
        check("t3_sat1", 32'(score_sat), 32'd1);
        frame();
        check("t3_clamp", 32'(score_disp), 32'd511);
        do_event(3'd1);
        frame();
        check("t3_hold511", 32'(score_disp),  32'd511);
        check("t3_lines69", 32'(lines_total), 32'd69);
        check("t3_sat_sticky", 32'(score_sat), 32'd1);

        // 4: clear_valid held high with n=2 gives ready 1,0,0 repeating; three commits
        restart();
        check("t4_sat_cleared", 32'(score_sat), 32'd0);
        clear_lines = 3'd2;
        clear_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            check("t4_ready_pattern", 32'(clear_ready), 32'((i % 3) == 0));
            if (i < 8) @(negedge clk_25MHz);
        end
        clear_valid = 1'b0;
        @(negedge clk_25MHz);
        check("t4_lines6", 32'(lines_total), 32'd6);
        repeat (3) @(negedge clk_25MHz);
        check("t4_no_recommit", 32'(lines_total), 32'd6);
        frame();
        check("t4_score9", 32'(score_disp), 32'd9);

        // 5: frame_start on the commit edge shows the old score for one frame
        clear_valid = 1'b1;
        clear_lines = 3'd1;
        @(negedge clk_25MHz);
        clear_valid = 1'b0;
        @(negedge clk_25MHz);
        frame_start = 1'b1;
        @(negedge clk_25MHz);
        frame_start = 1'b0;
        check("t5_disp_old", 32'(score_disp),  32'd9);
        check("t5_lines7",   32'(lines_total), 32'd7);
        frame();
        check("t5_disp_new", 32'(score_disp), 32'd10);

        // 6: restart during CALC aborts the event
        do_event(3'd2);
        frame();
        check("t6_pre_disp", 32'(score_disp), 32'd13);
        clear_valid = 1'b1;
        clear_lines = 3'd3;
        @(negedge clk_25MHz);
        clear_valid  = 1'b0;
        game_restart = 1'b1;
        @(negedge clk_25MHz);
        game_restart = 1'b0;
        check("t6_ready", 32'(clear_ready), 32'd1);
        check("t6_lines", 32'(lines_total), 32'd0);
        check("t6_level", 32'(level),       32'd0);
        check("t6_disp",  32'(score_disp),  32'd0);
        repeat (3) @(negedge clk_25MHz);
        check("t6_no_commit", 32'(lines_total), 32'd0);

        // restart in the same cycle as clear_valid blocks the accept
        clear_valid  = 1'b1;
        clear_lines  = 3'd4;
        game_restart = 1'b1;
        @(negedge clk_25MHz);
        clear_valid  = 1'b0;
        game_restart = 1'b0;
        check("t6_no_accept", 32'(clear_ready), 32'd1);
        repeat (3) @(negedge clk_25MHz);
        check("t6_no_accept_lines", 32'(lines_total), 32'd0);

        // illegal counts 0 and 6 are accepted but change nothing
        do_event(3'd1);
        do_event(3'd0);
        do_event(3'd6);
        check("t6_illegal_lines", 32'(lines_total), 32'd1);
        frame();
        check("t6_illegal_score", 32'(score_disp), 32'd1);

        // asynchronous reset mid-event clears immediately and nothing commits afterwards
        clear_valid = 1'b1;
        clear_lines = 3'd4;
        @(negedge clk_25MHz);
        clear_valid = 1'b0;
        #5;
        rst_n = 1'b0;
        #1;
        check("async_lines", 32'(lines_total), 32'd0);
        check("async_disp",  32'(score_disp),  32'd0);
        check("async_ready", 32'(clear_ready), 32'd1);
        @(negedge clk_25MHz);
        rst_n = 1'b1;
        repeat (3) @(negedge clk_25MHz);
        check("async_no_commit", 32'(lines_total), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
